cache_2way_ctrl: RTL and testbench
==================================

CACHE_2WAY_CTRL -- requirements
Module: cache_2way_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width.
REQ-002 SHALL have parameter SETS, default 16, number of sets (power of two, >=2).
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, >=2).
REQ-004 SHALL derive OFF_W=log2(LINE_WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W; addr = {tag, index, offset}.
REQ-005 SHALL have port: clk  in  1  single clock, rising edge.
REQ-006 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: cpu_rd, cpu_wr  in  1  CPU read/write request, held until stall low.
REQ-008 SHALL have ports: cpu_addr  in  ADDR_W  word address; cpu_wdata  in  32  write data.
REQ-009 SHALL have ports: cpu_rdata  out  32  read data; stall  out  1  CPU must hold request.
REQ-010 SHALL have ports: mem_rd_req, mem_wr_req  out  1; mem_addr  out  ADDR_W; mem_wdata  out  32.
REQ-011 SHALL have ports: mem_rdata  in  32*LINE_WORDS  refill line; mem_ready  in  1  one-cycle memory completion.

Function
REQ-012 SHALL be 2-way set-associative; each way stores per set valid, TAG_W tag, one line; one LRU bit per set.
REQ-013 SHALL signal hit when either way at index is valid with matching tag; cpu_rdata = hitting way's word at offset, combinational.
REQ-014 SHALL use FSM states IDLE, REFILL, WRITE; reset state IDLE.
REQ-015 IDLE, read hit: stall=0 same cycle, no state change, LRU points to other way at the next edge.
REQ-016 IDLE, read miss: stall=1 combinationally; next state REFILL.
REQ-017 REFILL: mem_rd_req=1, mem_addr={tag,index,0}, stall=1; on mem_ready write line into victim, set valid/tag, LRU = other way, return to IDLE; the read then hits (miss latency = memory cycles + 1).
REQ-018 Victim SHALL be: first invalid way (way0 before way1), else way named by LRU.
REQ-019 Writes SHALL be write-through, no-allocate: write hit updates the word in the hitting way at the IDLE->WRITE edge and updates LRU; write miss leaves the array unchanged.
REQ-020 Any write: stall=1 combinationally, next state WRITE; WRITE drives mem_wr_req=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata until mem_ready, then IDLE with stall=0 for one cycle.
REQ-021 cpu_rd and cpu_wr both high SHALL be treated as write only.
REQ-022 mem_rd_req and mem_wr_req SHALL never be high together; mem_ready in IDLE SHALL be ignored.
REQ-023 Request outputs SHALL remain stable while waiting; mem_ready in the same cycle as entry has no effect until the next edge.

Reset
REQ-024 Reset SHALL asynchronously clear all valid and LRU bits, FSM to IDLE; mem_rd_req=mem_wr_req=0, stall=0 with no request, cpu_rdata=0 when no hit; line data not reset.
REQ-025 Reset mid-REFILL/WRITE SHALL abandon the transaction with no array update.

Configuration
REQ-026 With CACHE_STATS_EN defined: outputs hit_cnt, miss_cnt (32 each) count IDLE read hits/misses once per request, saturate at all-ones, clear on reset.
REQ-027 Without CACHE_STATS_EN: the ports and counters SHALL be absent.

Structure
REQ-028 Package cache_pkg SHALL hold the FSM state typedef and word width constant (32).
REQ-029 Per-way storage (valid, tag, data, synchronous line/word write, async read) SHALL be sub-module cache_way, instantiated twice.

Verification (defaults: OFF_W=2, IDX_W=4, TAG_W=4)
REQ-030 Reset, read 0x015, mem_rdata=line {W3..W0=0xD,0xC,0xB,0xA}, mem_ready after 3 cycles -> mem_rd_req with mem_addr 0x014, then cpu_rdata=0xB, stall low 5 cycles after request.
REQ-031 Fill 0x014 (way0) and 0x054 (way1), read 0x014, then miss 0x094 -> 0x054's line evicted; 0x014 still hits, 0x054 misses.
REQ-032 Write 0x016=0xCAFEF00D on hit -> mem_wr_req with addr 0x016; next read 0x016 hits with 0xCAFEF00D.
REQ-033 Write miss 0x3F0 -> one mem write, subsequent read 0x3F0 misses (no allocate).
REQ-034 rst low during REFILL -> mem_rd_req drops immediately, read of same address misses again.
REQ-035 CACHE_STATS_EN: 2 misses + 3 hits -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way set-associative cache controller.
package cache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid bit, tag and line, with asynchronous read
// and synchronous whole-line (refill) or single-word (write hit) update.
module cache_way
    import cache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 4,
    localparam int IDX_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IDX_W-1:0]             idx,
    input  logic [OFF_W-1:0]             off,
    input  logic                         line_we,
    input  logic [TAG_W-1:0]             line_tag,
    input  logic [WORD_W*LINE_WORDS-1:0] line_data,
    input  logic                         word_we,
    input  logic [WORD_W-1:0]            word_data,
    output logic                         valid,
    output logic [TAG_W-1:0]             tag,
    output logic [WORD_W-1:0]            word
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [WORD_W-1:0] data_q [SETS][LINE_WORDS];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else if (line_we) valid_q[idx] <= 1'b1;
    end

    // NOTE: tag and data arrays have no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx] <= line_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_q[idx][w] <= line_data[w*WORD_W +: WORD_W];
            end
        end else if (word_we) begin
            data_q[idx][off] <= word_data;
        end
    end

    assign valid = valid_q[idx];
    assign tag   = tag_q[idx];
    assign word  = data_q[idx][off];

endmodule

// File: rtl/cache_2way_ctrl.sv
// 2-way set-associative, write-through/no-allocate cache controller with per-set LRU.
// Optional feature macro CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module cache_2way_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_rd,
    input  logic                         cpu_wr,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [WORD_W-1:0]            cpu_wdata,
    output logic [WORD_W-1:0]            cpu_rdata,
    output logic                         stall,
    output logic                         mem_rd_req,
    output logic                         mem_wr_req,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic [WORD_W*LINE_WORDS-1:0] mem_rdata,
    input  logic                         mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              valid0, valid1, hit0, hit1, hit, victim;
    logic [TAG_W-1:0]  tag0, tag1;
    logic [WORD_W-1:0] word0, word1;
    logic              line_we0, line_we1, word_we0, word_we1;
    logic              lru_we, lru_val;
    logic [SETS-1:0]   lru;
    logic              wr_done;
    state_t            state, state_nxt;

    assign {tag, idx, off} = cpu_addr;

    cache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way0 (
        .clk(clk), .rst(rst), .idx(idx), .off(off),
        .line_we(line_we0), .line_tag(tag), .line_data(mem_rdata),
        .word_we(word_we0), .word_data(cpu_wdata),
        .valid(valid0), .tag(tag0), .word(word0)
    );

    cache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_way1 (
        .clk(clk), .rst(rst), .idx(idx), .off(off),
        .line_we(line_we1), .line_tag(tag), .line_data(mem_rdata),
        .word_we(word_we1), .word_data(cpu_wdata),
        .valid(valid1), .tag(tag1), .word(word1)
    );

    assign hit0   = valid0 && (tag0 == tag);
    assign hit1   = valid1 && (tag1 == tag) && !hit0;
    assign hit    = hit0 || hit1;
    assign victim = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[idx]);

    always_comb begin
        cpu_rdata = hit0 ? word0 : (hit1 ? word1 : '0);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        line_we0   = 1'b0;
        line_we1   = 1'b0;
        word_we0   = 1'b0;
        word_we1   = 1'b0;
        lru_we     = 1'b0;
        lru_val    = 1'b0;
        case (state)
            IDLE: begin
                // The cycle after a write completes releases the CPU's still-held request.
                if (!wr_done) begin
                    if (cpu_wr) begin
                        stall     = 1'b1;
                        state_nxt = WRITE;
                        word_we0  = hit0;
                        word_we1  = hit1;
                        lru_we    = hit;
                        lru_val   = hit0;
                    end else if (cpu_rd) begin
                        if (hit) begin
                            lru_we  = 1'b1;
                            lru_val = hit0;
                        end else begin
                            stall     = 1'b1;
                            state_nxt = REFILL;
                        end
                    end
                end
            end
            REFILL: begin
                stall      = 1'b1;
                mem_rd_req = 1'b1;
                mem_addr   = {tag, idx, {OFF_W{1'b0}}};
                if (mem_ready) begin
                    line_we0  = !victim;
                    line_we1  = victim;
                    lru_we    = 1'b1;
                    lru_val   = !victim;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                stall      = 1'b1;
                mem_wr_req = 1'b1;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lru     <= '0;
            wr_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_done <= (state == WRITE) && mem_ready;
            if (lru_we) lru[idx] <= lru_val;
        end
    end

`ifdef CACHE_STATS_EN
    // The hit right after a refill belongs to the request already counted as a miss.
    logic rf_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            rf_done  <= 1'b0;
        end else begin
            rf_done <= (state == REFILL) && mem_ready;
            if (state == IDLE && !wr_done && !cpu_wr && cpu_rd) begin
                if (hit) begin
                    if (!rf_done && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                end else if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Self-checking bench for cache_2way_ctrl: directed scenarios plus random traffic
// against a per-set recency-list cache model and a flat word-addressed memory model.
module tb_cache_2way_ctrl;
    import cache_pkg::*;

    localparam int ADDR_W     = 10;
    localparam int SETS       = 16;
    localparam int LINE_WORDS = 4;
    localparam int NWORDS     = 1 << ADDR_W;

    logic                         clk, rst_n;
    logic                         cpu_rd, cpu_wr;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [31:0]                  cpu_wdata, cpu_rdata;
    logic                         stall, mem_rd_req, mem_wr_req, mem_ready;
    logic [ADDR_W-1:0]            mem_addr;
    logic [31:0]                  mem_wdata;
    logic [32*LINE_WORDS-1:0]     mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]                  hit_cnt, miss_cnt;
`endif

    cache_2way_ctrl #(.ADDR_W(ADDR_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
        .clk(clk), .rst(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: memory contents, and per set the resident tags ordered most-recent first.
    logic [31:0] mem_model [NWORDS];
    int unsigned resid [SETS][$];
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic int find_tag(input int s, input int unsigned t);
        for (int i = 0; i < resid[s].size(); i++) if (resid[s][i] == t) return i;
        return -1;
    endfunction

    task automatic touch(input int s, input int pos);
        int unsigned t;
        t = resid[s][pos];
        resid[s].delete(pos);
        resid[s].push_front(t);
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) resid[s].delete();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    function automatic logic [32*LINE_WORDS-1:0] line_of(input int addr);
        logic [32*LINE_WORDS-1:0] l;
        int base;
        base = addr & ~(LINE_WORDS - 1);
        for (int w = 0; w < LINE_WORDS; w++) l[w*32 +: 32] = mem_model[base + w];
        return l;
    endfunction

    // Starts at a negedge, acts as the memory with `lat` busy cycles, ends at a negedge.
    task automatic access(input bit rd, input bit wr, input int addr, input logic [31:0] wdata,
                          input int lat);
        int          s, pos, exp_lat, busy, c;
        int unsigned t;
        bit          exp_hit, done;
        logic [31:0] exp_data;
        s        = (addr >> 2) % SETS;
        t        = addr >> 6;
        pos      = find_tag(s, t);
        exp_hit  = (pos >= 0);
        exp_lat  = (!wr && exp_hit) ? 0 : lat + 1;
        exp_data = mem_model[addr];
        busy     = 0;
        done     = 0;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = ADDR_W'(addr);
        cpu_wdata = wdata;
        for (c = 0; c < 64 && !done; c++) begin
            #1;
            check("req_exclusive", {1'b0, mem_rd_req & mem_wr_req}, 0);
            if (!stall) begin
                check(wr ? "wr_latency" : "rd_latency", c, exp_lat);
                if (!wr) check("rd_data", cpu_rdata, exp_data);
                done = 1;
            end else if (mem_rd_req) begin
                busy++;
                check("refill_addr", mem_addr, addr & ~(LINE_WORDS - 1));
                mem_rdata = line_of(addr);
                mem_ready = (busy == lat);
            end else if (mem_wr_req) begin
                busy++;
                check("wr_addr", mem_addr, addr);
                check("wr_data", mem_wdata, wdata);
                mem_ready = (busy == lat);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            mem_ready = 1'b0;
        end
        if (!done) check("stall_timeout", {63'd0, done}, 1);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        if (wr) begin
            mem_model[addr] = wdata;
            if (exp_hit) touch(s, pos);
        end else if (exp_hit) begin
            touch(s, pos);
            exp_hits++;
        end else begin
            resid[s].push_front(t);
            if (resid[s].size() > 2) void'(resid[s].pop_back());
            exp_misses++;
        end
    endtask

    task automatic idle_cycle();
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("idle_stall", stall, 0);
        check("idle_reqs", {mem_rd_req, mem_wr_req}, 0);
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic check_stats();
`ifdef CACHE_STATS_EN
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_misses);
`endif
    endtask

    initial begin
        int a, r;
        rst_n     = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < NWORDS; i++) mem_model[i] = $urandom;
        model_reset();

        #2;
        check("rst_stall", stall, 0);
        check("rst_reqs", {mem_rd_req, mem_wr_req}, 0);
        check("rst_rdata", cpu_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_rdata", cpu_rdata, 0);
        @(negedge clk);

        // Read miss with a known line, memory answering in its 4th busy cycle.
        mem_model[10'h014] = 32'hA;
        mem_model[10'h015] = 32'hB;
        mem_model[10'h016] = 32'hC;
        mem_model[10'h017] = 32'hD;
        access(1, 0, 10'h015, 0, 4);

        // LRU eviction: 0x014 in way0, 0x054 in way1, touch 0x014, then 0x094 evicts 0x054.
        access(1, 0, 10'h054, 0, 2);
        access(1, 0, 10'h014, 0, 1);
        access(1, 0, 10'h094, 0, 3);
        access(1, 0, 10'h014, 0, 1);
        access(1, 0, 10'h054, 0, 1);

        // Write hit updates the cached word; write miss does not allocate.
        access(0, 1, 10'h016, 32'hCAFEF00D, 2);
        access(1, 0, 10'h016, 0, 1);
        access(0, 1, 10'h3F0, 32'h12345678, 1);
        access(1, 0, 10'h3F0, 0, 2);
        check_stats();

        // Reset in the middle of a refill abandons it.
        cpu_rd   = 1'b1;
        cpu_addr = 10'h2A8;
        repeat (3) @(negedge clk);
        #1;
        check("refill_active", mem_rd_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_drops_rdreq", mem_rd_req, 0);
        cpu_rd = 1'b0;
        #1;
        check("rst_stall_noreq", stall, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 0, 10'h2A8, 0, 2);
        access(1, 0, 10'h015, 0, 1);

        // Random traffic over a few sets and tags to force hits, evictions and both-high requests.
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r < 6)      access(1, 0, a, 0, $urandom_range(1, 4));
            else if (r < 9) access(0, 1, a, $urandom, $urandom_range(1, 4));
            else            access(1, 1, a, $urandom, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        check_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
